// File: rtl/lfsr_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prbs_checker
//  Purpose  : Receive-side checker for an 8-bit XNOR LFSR stream (taps 7,3).
//             Self-synchronises, declares lock, counts bit errors, drops lock.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_prbs_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_THRESH);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]         FILL_FULL  = 4'd8;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [7:0]         s_q,         s_d;
  logic [3:0]         fill_q,      fill_d;
  logic [MATCH_W-1:0] match_q,     match_d;
  logic [WIN_W-1:0]   win_q,       win_d;
  logic [WERR_W-1:0]  win_err_q,   win_err_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic               pred;
  logic               mis;
  logic [MATCH_W-1:0] match_inc;
  logic [WERR_W-1:0]  win_err_new;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    pred        = ~(s_q[7] ^ s_q[3]);
    mis         = in_bit ^ pred;
    match_inc   = match_q + MATCH_W'(1);
    win_err_new = win_err_q + WERR_W'(mis);

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          s_d = {s_q[6:0], in_bit};
          if (fill_q != FILL_FULL) begin
            fill_d  = fill_q + 4'd1;
            match_d = '0;
          end else if (mis || (s_q == 8'hFF)) begin
            // all-ones is the XNOR lock-up state and never a valid sync point
            match_d = '0;
          end else if (match_inc == MATCH_LOCK) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_d     = '0;
            win_err_d = '0;
          end else begin
            match_d = match_inc;
          end
        end

        default: begin
          // free-running local copy: received errors never enter the register
          s_d = {s_q[6:0], pred};
          if (bit_count_q != CNT_MAX) bit_count_d = bit_count_q + CNT_W'(1);
          if (mis) begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
          end
          if (win_err_new == WERR_LOSS) begin
            state_d   = ST_HUNT;
            fill_d    = '0;
            match_d   = '0;
            win_d     = '0;
            win_err_d = '0;
          end else if (win_q == WIN_LAST) begin
            win_d     = '0;
            win_err_d = '0;
          end else begin
            win_d     = win_q + WIN_W'(1);
            win_err_d = win_err_new;
          end
        end
      endcase
    end

    if (clear_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      s_q         <= 8'h00;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_prbs_checker
//  Purpose  : Scenario table, directed corner sequences and randomized stream
//             compared against a behavioural model of the checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_prbs_checker;

  localparam int CNT_W = 16;
  localparam int LOCK  = 16;
  localparam int LOSS  = 4;
  localparam int WIN   = 64;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_bit;
  logic             in_valid;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  lfsr_prbs_checker #(
    .LOCK_THRESH(LOCK),
    .LOSS_THRESH(LOSS),
    .WINDOW     (WIN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int pulses_seen;
  int g;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: history queue holds the last 8 reference bits, oldest first
  bit m_locked, m_pulse;
  bit m_q[$];
  int m_fill, m_run, m_win, m_werr, m_err, m_bit;

  task automatic model_step(bit rst, bit vld, bit b, bit clr);
    bit pred, wrong, ones;
    if (rst) begin
      m_locked = 0; m_pulse = 0;
      m_q = {};
      for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
      m_fill = 0; m_run = 0; m_win = 0; m_werr = 0; m_err = 0; m_bit = 0;
      return;
    end
    m_pulse = 0;
    if (vld) begin
      pred  = !(m_q[0] ^ m_q[4]);
      wrong = (b != pred);
      ones  = 1;
      foreach (m_q[i]) if (!m_q[i]) ones = 0;
      if (!m_locked) begin
        if (m_fill < 8) begin
          m_fill++;
          m_run = 0;
        end else if (wrong || ones) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == LOCK) begin m_locked = 1; m_win = 0; m_werr = 0; end
        end
        m_q.push_back(b);
      end else begin
        m_q.push_back(pred);
        if (m_bit < MAXC) m_bit++;
        if (wrong) begin
          m_pulse = 1;
          if (m_err < MAXC) m_err++;
          m_werr++;
        end
        if (m_werr == LOSS) begin
          m_locked = 0; m_fill = 0; m_run = 0;
        end else if (m_win == WIN - 1) begin
          m_win = 0; m_werr = 0;
        end else begin
          m_win++;
        end
      end
      void'(m_q.pop_front());
    end
    if (clr) begin m_err = 0; m_bit = 0; end
  endtask

  task automatic gen_next(output bit b);
    b = !(((g >> 7) & 1) ^ ((g >> 3) & 1));
    g = ((g << 1) | int'(b)) & 255;
  endtask

  task automatic step(bit rst, bit vld, bit b, bit clr);
    reset = rst; in_valid = vld; in_bit = b; clear_cnt = clr;
    @(posedge clk);
    #1;
    model_step(rst, vld, b, clr);
    chk("locked",    int'(locked),    int'(m_locked));
    chk("err_pulse", int'(err_pulse), int'(m_pulse));
    chk("err_count", int'(err_count), m_err);
    chk("bit_count", int'(bit_count), m_bit);
    pulses_seen += int'(err_pulse);
  endtask

  // Scenario: reset, then n generator bits (1-based) with listed bits inverted
  typedef struct packed {
    int          n;
    logic [47:0] e;
    logic        exp_locked;
    int          exp_err;
    int          exp_bit;
    int          exp_pulses;
  } scen_t;

  scen_t tbl[9];

  function automatic scen_t mk(int n, int e0, int e1, int e2, int e3, int e4, int e5,
                               bit l, int er, int bc, int p);
    scen_t s;
    s.n = n;
    s.e = {8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    s.exp_locked = l; s.exp_err = er; s.exp_bit = bc; s.exp_pulses = p;
    return s;
  endfunction

  task automatic run_gen(int n, logic [47:0] e);
    bit b, inv;
    g = 0;
    for (int i = 1; i <= n; i++) begin
      gen_next(b);
      inv = 0;
      for (int j = 0; j < 6; j++) if (int'(e[j*8 +: 8]) == i) inv = 1;
      step(0, 1, b ^ inv, 0);
    end
  endtask

  initial begin
    bit b;
    int nvalid, lock_seen, pulse_any;

    tbl[0] = mk( 23,  0,  0,  0,  0,   0,   0, 0, 0,   0, 0);
    tbl[1] = mk( 24,  0,  0,  0,  0,   0,   0, 1, 0,   0, 0);
    tbl[2] = mk( 40, 30,  0,  0,  0,   0,   0, 1, 1,  16, 1);
    tbl[3] = mk( 40, 30, 31, 32, 33,   0,   0, 0, 4,   9, 4);
    tbl[4] = mk( 57, 30, 31, 32, 33,   0,   0, 1, 4,   9, 4);
    tbl[5] = mk( 56, 30, 31, 32, 33,   0,   0, 0, 4,   9, 4);
    tbl[6] = mk(160, 30, 40, 50, 100, 110, 120, 1, 6, 136, 6);
    tbl[7] = mk(100, 80, 85, 88, 89,   0,   0, 1, 4,  76, 4);
    tbl[8] = mk( 90, 60, 70, 80, 88,   0,   0, 0, 4,  64, 4);

    pulses_seen = 0;
    step(1, 0, 0, 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);

    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, 0);
      pulses_seen = 0;
      run_gen(tbl[k].n, tbl[k].e);
      chk($sformatf("scen%0d_locked", k),  int'(locked),    int'(tbl[k].exp_locked));
      chk($sformatf("scen%0d_err", k),     int'(err_count), tbl[k].exp_err);
      chk($sformatf("scen%0d_bits", k),    int'(bit_count), tbl[k].exp_bit);
      chk($sformatf("scen%0d_pulses", k),  pulses_seen,     tbl[k].exp_pulses);
    end

    // clear_cnt coincident with a counted error: clear wins, pulse still fires
    step(1, 0, 0, 0);
    run_gen(29, '0);
    gen_next(b);
    step(0, 1, ~b, 1);
    chk("clr_pulse", int'(err_pulse), 1);
    chk("clr_err",   int'(err_count), 0);
    chk("clr_bits",  int'(bit_count), 0);
    gen_next(b);
    step(0, 1, b, 0);
    chk("clr_next_bits",  int'(bit_count), 1);
    chk("clr_next_pulse", int'(err_pulse), 0);

    // constant all-ones stream never locks
    step(1, 0, 0, 0);
    lock_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 1, 0);
      lock_seen |= int'(locked);
    end
    chk("allones_never_locked", lock_seen, 0);

    // reset while locked with err_count=5, then relock from a fresh generator
    step(1, 0, 0, 0);
    run_gen(120, {8'd0, 8'd110, 8'd100, 8'd50, 8'd40, 8'd30});
    chk("prereset_err", int'(err_count), 5);
    chk("prereset_locked", int'(locked), 1);
    gen_next(b);
    step(1, 1, ~b, 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse",  int'(err_pulse), 0);
    chk("rst_err",    int'(err_count), 0);
    chk("rst_bits",   int'(bit_count), 0);
    run_gen(24, '0);
    chk("rst_relock", int'(locked), 1);

    // random in_valid gaps: lock point counted in valid bits only
    step(1, 0, 0, 0);
    g = 0; nvalid = 0; pulse_any = 0;
    for (int c = 0; c < 400 && nvalid < 24; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        gen_next(b);
        step(0, 1, b, 0);
        nvalid++;
        if (nvalid == 23) chk("gap_not_locked_23", int'(locked), 0);
      end else begin
        step(0, 0, $urandom_range(1, 0) == 1, 0);
      end
      pulse_any |= int'(err_pulse);
    end
    chk("gap_valid_bits", nvalid, 24);
    chk("gap_locked_24", int'(locked), 1);
    for (int c = 0; c < 100; c++) begin
      if ($urandom_range(1, 0) == 1) begin gen_next(b); step(0, 1, b, 0); end
      else step(0, 0, 0, 0);
      pulse_any |= int'(err_pulse);
    end
    chk("gap_no_pulse", pulse_any, 0);

    // randomized stream with errors, gaps, clears and occasional reset
    step(1, 0, 0, 0);
    g = 0;
    for (int c = 0; c < 4000; c++) begin
      bit vld, err, clr, rst;
      vld = ($urandom_range(3, 0) != 0);
      err = ($urandom_range(29, 0) == 0);
      clr = ($urandom_range(199, 0) == 0);
      rst = ($urandom_range(699, 0) == 0);
      if (vld) begin
        gen_next(b);
        step(rst, 1, b ^ err, clr);
      end else begin
        step(rst, 0, $urandom_range(1, 0) == 1, clr);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
